// File: rtl/axi4_rd_id_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// axi4_rd_id_scheduler_pkg
// Shared definitions for the AXI4 read-ID scheduler:
//   - default sizes (requesters, ID width, tag width, in-flight limit)
//   - cnt_width(): width of a per-ID outstanding counter
//   - ar_stage_t: contents of the single AR issue slot
//   - stage_state_e: occupancy of that slot
// -----------------------------------------------------------------------------
package axi4_rd_id_scheduler_pkg;

  localparam int DEF_NREQ         = 4;
  localparam int DEF_ID_W         = 2;
  localparam int DEF_TAG_W        = 7;
  localparam int DEF_MAX_INFLIGHT = 4;

  // Enough bits to hold 0..max_inflight inclusive.
  function automatic int cnt_width(input int max_inflight);
    return $clog2(max_inflight + 1);
  endfunction

  typedef struct packed {
    logic [DEF_ID_W-1:0]  id;
    logic [DEF_TAG_W-1:0] tag;
  } ar_stage_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } stage_state_e;

endpackage

// File: rtl/axi4_rd_id_scheduler_rr_arbiter.sv
// -----------------------------------------------------------------------------
// axi4_rd_id_scheduler_rr_arbiter
// NREQ-wide round-robin arbiter. The search starts at the pointer; on a grant
// the pointer moves to one past the winner, otherwise it holds.
// Ports:
//   clock, reset_n : clock, asynchronous active-low reset
//   eligible       : per-requester eligibility mask
//   advance        : grant permitted this cycle
//   grant          : one-hot grant (zero when no grant)
//   grant_idx      : index of the winner (valid when grant_valid)
//   grant_valid    : a grant is made this cycle
// NREQ must equal 2**IDX_W so pointer arithmetic wraps naturally.
// -----------------------------------------------------------------------------
module axi4_rd_id_scheduler_rr_arbiter
  import axi4_rd_id_scheduler_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int IDX_W = DEF_ID_W
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [NREQ-1:0]  eligible,
  input  logic             advance,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             found;
  logic [IDX_W-1:0] cand;

  // NOTE: every variable written in an always_comb gets a default on entry;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = ptr_q + IDX_W'(i);
      if (!found && eligible[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
    grant_valid = advance && found;
    grant       = grant_valid ? (NREQ'(1) << grant_idx) : '0;
    ptr_d       = grant_valid ? (grant_idx + IDX_W'(1)) : ptr_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end

endmodule

// File: rtl/axi4_rd_id_scheduler.sv
// -----------------------------------------------------------------------------
// axi4_rd_id_scheduler
// Shares one AXI4 AR channel among NREQ requesters (requester r uses ID r).
// Round-robin grant with a per-ID in-flight limit, a single-slot AR stage,
// tag-queue push on AR fire and pop on R last beats.
// Ports:
//   clock, reset_n           : clock, asynchronous active-low reset
//   req_valid/req_tag        : per-requester request and tag (slice r)
//   req_ready                : one-hot combinational grant
//   ar_valid/ar_id/ar_tag    : AR stage outputs, ar_ready : downstream accept
//   r_valid/r_id/r_last      : observed R beats
//   enq_valid/enq_tag        : tag queue push (on AR fire)
//   deq_valid                : tag queue pop (on R last with outstanding)
//   busy                     : counters non-zero or AR stage full
//   err                      : sticky, R last with nothing outstanding
// Optional: define AXI4_RD_ID_QUIESCE_EN to add quiesce_req (blocks new
// grants) and idle (registered quiesce_req && !busy).
// -----------------------------------------------------------------------------
module axi4_rd_id_scheduler
  import axi4_rd_id_scheduler_pkg::*;
#(
  parameter int NREQ         = DEF_NREQ,
  parameter int ID_W         = DEF_ID_W,
  parameter int TAG_W        = DEF_TAG_W,
  parameter int MAX_INFLIGHT = DEF_MAX_INFLIGHT
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*TAG_W-1:0] req_tag,
  output logic [NREQ-1:0]       req_ready,
  output logic                  ar_valid,
  output logic [ID_W-1:0]       ar_id,
  output logic [TAG_W-1:0]      ar_tag,
  input  logic                  ar_ready,
  input  logic                  r_valid,
  input  logic [ID_W-1:0]       r_id,
  input  logic                  r_last,
  output logic [NREQ-1:0]       enq_valid,
  output logic [TAG_W-1:0]      enq_tag,
  output logic [NREQ-1:0]       deq_valid,
  output logic                  busy,
`ifdef AXI4_RD_ID_QUIESCE_EN
  input  logic                  quiesce_req,
  output logic                  idle,
`endif
  output logic                  err
);

  localparam int CNT_W = cnt_width(MAX_INFLIGHT);

  stage_state_e     state_q, state_d;
  ar_stage_t        stage_q, stage_d;
  logic [CNT_W-1:0] cnt_q [NREQ];
  logic [CNT_W-1:0] cnt_d [NREQ];
  logic             err_q, err_d;

  logic [NREQ-1:0]  eligible;
  logic             grant_en;
  logic [NREQ-1:0]  grant;
  logic [ID_W-1:0]  grant_idx;
  logic             grant_valid;
  logic             ar_fire;
  logic             retire;
  logic             retire_ok;

  // A full counter masks its requester, so the arbiter skips it.
  always_comb begin
    for (int r = 0; r < NREQ; r++) begin
      eligible[r] = req_valid[r] && (cnt_q[r] < CNT_W'(MAX_INFLIGHT));
    end
  end

  // A new grant may only land in the slot if it is empty or leaving now.
`ifdef AXI4_RD_ID_QUIESCE_EN
  assign grant_en = ((state_q == ST_EMPTY) || ar_ready) && !quiesce_req;
`else
  assign grant_en = (state_q == ST_EMPTY) || ar_ready;
`endif

  axi4_rd_id_scheduler_rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (ID_W)
  ) u_arb (
    .clock       (clock),
    .reset_n     (reset_n),
    .eligible    (eligible),
    .advance     (grant_en),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign ar_fire   = (state_q == ST_FULL) && ar_ready;
  assign retire    = r_valid && r_last;
  assign retire_ok = retire && (cnt_q[r_id] != '0);

  // AR stage: a grant always (re)loads the slot; otherwise a fire empties it.
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    unique case (state_q)
      ST_EMPTY: if (grant_valid) state_d = ST_FULL;
      ST_FULL:  if (!grant_valid && ar_ready) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
    if (grant_valid) begin
      stage_d.id  = grant_idx;
      stage_d.tag = req_tag[grant_idx*TAG_W +: TAG_W];
    end
  end

  // Counters count from grant, so the staged request is part of the limit.
  // A simultaneous grant and retire on one ID leaves its count unchanged.
  always_comb begin
    for (int r = 0; r < NREQ; r++) begin
      cnt_d[r] = cnt_q[r];
      if (grant[r] && !(retire_ok && (r_id == ID_W'(r))))
        cnt_d[r] = cnt_q[r] + CNT_W'(1);
      else if (!grant[r] && retire_ok && (r_id == ID_W'(r)))
        cnt_d[r] = cnt_q[r] - CNT_W'(1);
    end
    err_d = err_q || (retire && !retire_ok);
  end

  always_comb begin
    busy = (state_q == ST_FULL);
    for (int r = 0; r < NREQ; r++) begin
      if (cnt_q[r] != '0) busy = 1'b1;
    end
  end

  assign req_ready = grant;
  assign ar_valid  = (state_q == ST_FULL);
  assign ar_id     = stage_q.id;
  assign ar_tag    = stage_q.tag;
  assign enq_valid = ar_fire ? (NREQ'(1) << stage_q.id) : '0;
  assign enq_tag   = stage_q.tag;
  assign deq_valid = retire_ok ? (NREQ'(1) << r_id) : '0;
  assign err       = err_q;

  // NOTE: the counter array is reset like ordinary flops because a zero count
  // is observable state; a RAM-backed array could not be cleared this way.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_EMPTY;
      stage_q <= '0;
      err_q   <= 1'b0;
      for (int r = 0; r < NREQ; r++) cnt_q[r] <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      err_q   <= err_d;
      for (int r = 0; r < NREQ; r++) cnt_q[r] <= cnt_d[r];
    end
  end

`ifdef AXI4_RD_ID_QUIESCE_EN
  logic idle_q, idle_d;

  assign idle_d = quiesce_req && !busy;
  assign idle   = idle_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) idle_q <= 1'b0;
    else          idle_q <= idle_d;
  end
`endif

endmodule
